// File: rtl/app_mult_seq.sv
// Iterative shift-add approximate multiplier, signed or unsigned per operation, with partial-product truncation.
// Latency: capture edge k, done high in the cycle after edge k+width2+1; one multiplier bit per RUN cycle.
// Backpressure: none; en is only sampled in IDLE and all inputs are ignored while busy.
module app_mult_seq #(
    parameter int width1 = 8,
    parameter int width2 = 8,
    parameter int TRUNC  = 0
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       en,
    input  logic                       signed_mode,
    input  logic [width1-1:0]          A,
    input  logic [width2-1:0]          B,
    input  logic                       cin,
    output logic                       busy,
    output logic                       done,
    output logic [width1+width2-1:0]   sum
);

    localparam int W  = width1 + width2;
    // Counter must hold 0..width2-1; keep at least one bit for width2 = 1.
    localparam int CW = (width2 > 1) ? $clog2(width2) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(width2 - 1);
    // Columns 0..TRUNC-1 are dropped from every partial product.
    localparam logic [W-1:0]  ONES     = '1;
    localparam logic [W-1:0]  PP_MASK  = ONES << TRUNC;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t               r_state;
    logic [W-1:0]         r_acc;
    logic [W-1:0]         r_mcand;    // magnitude of A, shifted left one column per step
    logic [width2-1:0]    r_mplier;   // magnitude of B, shifted right so bit 0 is the current bit
    logic [CW-1:0]        r_cnt;
    logic                 r_neg;
    logic                 r_cin;
    logic                 r_busy;
    logic                 r_done;
    logic [W-1:0]         r_sum;

    logic [width1-1:0]    w_mag_a;
    logic [width2-1:0]    w_mag_b;
    logic                 w_neg;
    logic [W-1:0]         w_pp;
    logic [W-1:0]         w_acc_next;
    logic [W-1:0]         w_signed_acc;
    logic [W-1:0]         w_result;

    // Magnitudes fit the operand width unsigned: the most negative value maps to 2^(width-1).
    assign w_mag_a = (signed_mode && A[width1-1]) ? -A : A;
    assign w_mag_b = (signed_mode && B[width2-1]) ? -B : B;
    assign w_neg   = signed_mode & (A[width1-1] ^ B[width2-1]);

    // Truncation acts on the magnitude product, so sign correction and cin come afterwards.
    assign w_pp         = r_mcand & PP_MASK;
    assign w_acc_next   = r_mplier[0] ? (r_acc + w_pp) : r_acc;
    assign w_signed_acc = r_neg ? -r_acc : r_acc;
    assign w_result     = w_signed_acc + W'(r_cin);

    // Control FSM and datapath: capture in IDLE, accumulate in RUN, publish in FIN.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_cin    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sum    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_mcand  <= {{width2{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_neg    <= w_neg;
                        r_cin    <= cin;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == LAST_BIT) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    // busy falls on the same edge that raises done.
                    r_sum   <= w_result;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;

endmodule

// File: tb/tb_app_mult_seq.sv
// Self-checking bench for app_mult_seq: exact (TRUNC=0) and truncated (TRUNC=4) instances share stimulus.
// A cycle-level reference model is compared against both instances on every falling edge.
// Directed cases also carry hand-computed literal results and latency figures.
module tb_app_mult_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        sm = 1'b0;
    logic        cin = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;

    logic        busy0, done0, busy4, done4;
    logic [15:0] sum0, sum4;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    app_mult_seq #(.width1(8), .width2(8), .TRUNC(0)) u_exact (
        .sys_clk(clk), .sys_rst_n(rst_n), .en(en), .signed_mode(sm),
        .A(a), .B(b), .cin(cin), .busy(busy0), .done(done0), .sum(sum0)
    );

    app_mult_seq #(.width1(8), .width2(8), .TRUNC(4)) u_trunc (
        .sys_clk(clk), .sys_rst_n(rst_n), .en(en), .signed_mode(sm),
        .A(a), .B(b), .cin(cin), .busy(busy4), .done(done4), .sum(sum4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference product straight from the arithmetic definition.
    function automatic logic [15:0] ref_mult(input logic s, input logic [7:0] x, input logic [7:0] y,
                                             input logic c, input int trunc);
        int ma, mb, p, r;
        ma = (s && x[7]) ? 256 - int'(x) : int'(x);
        mb = (s && y[7]) ? 256 - int'(y) : int'(y);
        if (trunc == 0) begin
            p = ma * mb;
        end else begin
            p = 0;
            for (int i = 0; i < 8; i++)
                if (((mb >> i) & 1) == 1)
                    p += ((ma << i) & ~((1 << trunc) - 1));
        end
        r = (s && (x[7] ^ y[7])) ? 65536 - p : p;
        r = r + int'(c);
        return 16'(r);
    endfunction

    // Timing model: a capture schedules a result exactly width2+1 edges later.
    int          m_rem   = 0;
    logic        m_busy  = 1'b0;
    logic        m_done  = 1'b0;
    logic [15:0] m_sum0  = '0;
    logic [15:0] m_sum4  = '0;
    logic [15:0] m_p0    = '0;
    logic [15:0] m_p4    = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_sum0 <= '0;
            m_sum4 <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_rem == 0) begin
                if (en) begin
                    m_rem  <= 9;
                    m_busy <= 1'b1;
                    m_p0   <= ref_mult(sm, a, b, cin, 0);
                    m_p4   <= ref_mult(sm, a, b, cin, 4);
                end
            end else if (m_rem == 1) begin
                m_rem  <= 0;
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_sum0 <= m_p0;
                m_sum4 <= m_p4;
            end else begin
                m_rem <= m_rem - 1;
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("model_busy0", 32'(busy0), 32'(m_busy));
        chk("model_done0", 32'(done0), 32'(m_done));
        chk("model_sum0",  32'(sum0),  32'(m_sum0));
        chk("model_busy4", 32'(busy4), 32'(m_busy));
        chk("model_done4", 32'(done4), 32'(m_done));
        chk("model_sum4",  32'(sum4),  32'(m_sum4));
    end

    // Wait (bounded) for done; report negedges waited and negedges busy was seen high.
    task automatic wait_done(output int cycles, output int busy_cnt);
        cycles = 0;
        busy_cnt = 0;
        while (!done0 && cycles < 40) begin
            if (busy0) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
        if (!done0) chk("done_timeout", 32'(done0), 32'd1);
    endtask

    task automatic run_case(input string name, input logic s, input logic [7:0] x, input logic [7:0] y,
                            input logic c, input logic [15:0] exp0, input logic [15:0] exp4);
        int cyc, bc;
        @(negedge clk);
        sm = s; a = x; b = y; cin = c; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        a = ~x; b = ~y; sm = ~s; cin = ~c;
        wait_done(cyc, bc);
        chk({name, "_latency"}, 32'(cyc), 32'd9);
        chk({name, "_busy_len"}, 32'(bc), 32'd9);
        chk({name, "_sum_exact"}, 32'(sum0), 32'(exp0));
        chk({name, "_sum_trunc"}, 32'(sum4), 32'(exp4));
    endtask

    initial begin
        int   cyc, bc, ndone;
        time  t1, t2;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_sum",  32'(sum0),  32'd0);
        rst_n = 1'b1;

        run_case("u200x150",  1'b0, 8'd200, 8'd150, 1'b0, 16'd30000, 16'd30000);
        run_case("s25xm6",    1'b1, 8'd25,  8'hFA,  1'b0, 16'hFF6A,  16'hFF70);
        run_case("sm128sq",   1'b1, 8'h80,  8'h80,  1'b0, 16'h4000,  16'h4000);
        run_case("u15x15",    1'b0, 8'd15,  8'd15,  1'b0, 16'd225,   16'd176);
        run_case("u15x15c",   1'b0, 8'd15,  8'd15,  1'b1, 16'd226,   16'd177);
        run_case("u255sq_c",  1'b0, 8'd255, 8'd255, 1'b1, 16'd65026, 16'd64977);
        run_case("zero_c",    1'b0, 8'd0,   8'd0,   1'b1, 16'd1,     16'd1);
        run_case("sm1x1",     1'b1, 8'hFF,  8'h01,  1'b0, 16'hFFFF,  16'h0000);

        // en held high: operands scrambled while busy, back-to-back captures 10 cycles apart
        @(negedge clk);
        sm = 1'b0; a = 8'd200; b = 8'd150; cin = 1'b0; en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom); b = 8'($urandom); sm = 1'($urandom); cin = 1'($urandom);
            @(negedge clk);
        end
        sm = 1'b0; a = 8'd0; b = 8'd0; cin = 1'b1;
        wait_done(cyc, bc);
        t1 = $time;
        chk("hold_first_sum", 32'(sum0), 32'd30000);
        @(negedge clk);
        wait_done(cyc, bc);
        t2 = $time;
        en = 1'b0;
        chk("hold_period", 32'((t2 - t1) / 10), 32'd10);
        chk("hold_second_sum", 32'(sum0), 32'd1);

        // en and operands toggled while busy: exactly one done, result intact
        @(negedge clk);
        sm = 1'b0; a = 8'd15; b = 8'd15; cin = 1'b0; en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            en = ~en; a = 8'($urandom); b = 8'($urandom);
            @(negedge clk);
        end
        en = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            if (done0) begin
                ndone++;
                chk("toggle_sum_exact", 32'(sum0), 32'd225);
                chk("toggle_sum_trunc", 32'(sum4), 32'd176);
            end
            @(negedge clk);
        end
        chk("toggle_done_count", 32'(ndone), 32'd1);

        // Reset three cycles after capture clears outputs without a clock edge
        @(negedge clk);
        sm = 1'b0; a = 8'd100; b = 8'd100; cin = 1'b0; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy0), 32'd0);
        chk("arst_done", 32'(done0), 32'd0);
        chk("arst_sum",  32'(sum0),  32'd0);
        chk("arst_sum_trunc", 32'(sum4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            if (done0 || done4) ndone++;
            @(negedge clk);
        end
        chk("arst_no_done", 32'(ndone), 32'd0);

        run_case("post_rst",  1'b1, 8'd25,  8'hFA,  1'b0, 16'hFF6A,  16'hFF70);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
